tt_um_aes_stream: RTL and testbench

Byte-serial AES front end for the Tiny Tapeout harness, generalised over key length (AES-128/192/256). The host shifts a key and a 128-bit block in over the 8-bit pins, then issues a start with an encrypt/decrypt mode bit. The block drives the existing `AES_Encrypt`/`AES_Decrypt` cores, captures the result, and streams it back one byte per read command. It replaces the fixed-plaintext top and becomes the chip's user module.

---
 rtl/aes_stream_pkg.sv | 135 +++++++++++++
 rtl/aes_cmd_sync.sv | 25 ++
 rtl/aes_stream_cores.sv | 54 +++++
 rtl/tt_um_aes_stream.sv | 152 +++++++++++++++
 tb/tb_tt_um_aes_stream.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_stream_pkg.sv
// Shared command codes, FSM states, status layout and the GF(2^8) helpers
// used by the combinational AES round logic.
package aes_stream_pkg;

    localparam logic [1:0] CMD_LOAD_KEY  = 2'b00;
    localparam logic [1:0] CMD_LOAD_DATA = 2'b01;
    localparam logic [1:0] CMD_START     = 2'b10;
    localparam logic [1:0] CMD_READ      = 2'b11;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam int unsigned STAT_BUSY      = 0;
    localparam int unsigned STAT_DONE      = 1;
    localparam int unsigned STAT_KEY_FULL  = 2;
    localparam int unsigned STAT_DATA_FULL = 3;

    localparam logic [7:0] UIO_OE = 8'h0F;

    // Word 0 is the MSB of any part-select, so w[4*r +: 4] is round key r.
    typedef logic [0:59][31:0] key_sched_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8); 0 maps to 0.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int unsigned i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int unsigned n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x;
        x = ginv(a);
        return x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        o = '0;
        for (int unsigned j = 0; j < 16; j++)
            o[8*j +: 8] = inv ? inv_sbox(s[8*j +: 8]) : sbox(s[8*j +: 8]);
        return o;
    endfunction

    // Byte b = 4*col + row sits at bits [8*(15-b) +: 8].
    function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        int unsigned  src;
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                src = inv ? ((c + 4 - r) % 4) : ((c + r) % 4);
                o[8*(15-4*c-r) +: 8] = s[8*(15-4*src-r) +: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        logic [7:0]   a [4];
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) a[r] = s[8*(15-4*c-r) +: 8];
            for (int unsigned r = 0; r < 4; r++) begin
                a0 = a[r];
                a1 = a[(r+1)%4];
                a2 = a[(r+2)%4];
                a3 = a[(r+3)%4];
                o[8*(15-4*c-r) +: 8] = inv ?
                    (gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09)) :
                    (xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3);
            end
        end
        return o;
    endfunction

    // kp holds the cipher key left-aligned; nk is the key length in words.
    function automatic key_sched_t expand_key(input logic [255:0] kp, input int unsigned nk);
        key_sched_t  w;
        logic [31:0] t;
        logic [7:0]  rc;
        w  = '0;
        rc = 8'h01;
        for (int unsigned i = 0; i < 60; i++) begin
            if (i < nk) begin
                w[i] = kp[255-32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                    rc = xtime(rc);
                end else if (nk > 6 && i % nk == 4) begin
                    t = sub_word(t);
                end
                w[i] = w[i-nk] ^ t;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/aes_cmd_sync.sv
// Three-flop strobe synchronizer; fires a one-cycle command pulse on the
// synchronized rising edge while the design is enabled.
module aes_cmd_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic strobe,
    output logic cmd_fire
);

    // sync_q[0]=s1, sync_q[1]=s2, sync_q[2]=s3
    logic [2:0] sync_q;
    logic [2:0] sync_d;

    always_comb begin
        sync_d   = ena ? {sync_q[1:0], strobe} : sync_q;
        cmd_fire = ena & sync_q[1] & ~sync_q[2];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= sync_d;
    end

endmodule

// File: rtl/aes_stream_cores.sv
// Combinational AES block cipher cores, sized by key length N (128/192/256).
// The full key schedule and all rounds settle within the caller's wait budget.
module AES_Encrypt
    import aes_stream_pkg::*;
#(
    parameter int N = 128
) (
    input  logic [127:0] in,
    input  logic [N-1:0] key,
    output logic [127:0] out
);

    localparam int unsigned NK = N / 32;
    localparam int unsigned NR = NK + 6;

    key_sched_t   w;
    logic [127:0] s;

    always_comb begin
        w = expand_key(256'(key) << (256 - N), NK);
        s = in ^ w[0 +: 4];
        for (int unsigned r = 1; r < NR; r++)
            s = mix_cols(shift_rows(sub_bytes(s, 1'b0), 1'b0), 1'b0) ^ w[4*r +: 4];
        out = shift_rows(sub_bytes(s, 1'b0), 1'b0) ^ w[4*NR +: 4];
    end

endmodule

module AES_Decrypt
    import aes_stream_pkg::*;
#(
    parameter int N = 128
) (
    input  logic [127:0] in,
    input  logic [N-1:0] key,
    output logic [127:0] out
);

    localparam int unsigned NK = N / 32;
    localparam int unsigned NR = NK + 6;

    key_sched_t   w;
    logic [127:0] s;

    // Straight inverse cipher: round keys consumed from last to first.
    always_comb begin
        w = expand_key(256'(key) << (256 - N), NK);
        s = in ^ w[4*NR +: 4];
        for (int unsigned i = 1; i < NR; i++)
            s = mix_cols(sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ w[4*(NR-i) +: 4], 1'b1);
        out = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ w[0 +: 4];
    end

endmodule

// File: rtl/tt_um_aes_stream.sv
// Byte-serial AES front end: shift in key and block, run encrypt or decrypt,
// then stream the 16-byte result out one byte per READ command.
module tt_um_aes_stream
    import aes_stream_pkg::*;
#(
    parameter int KEY_BITS  = 128,
    parameter int CORE_WAIT = 2
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    localparam int KEY_BYTES = KEY_BITS / 8;
    localparam int KCW       = $clog2(KEY_BYTES + 1);
    localparam int WW        = $clog2(CORE_WAIT + 1);
    localparam logic [KCW-1:0] KEY_FULL_CNT = KCW'(KEY_BYTES);

    state_e              state_q, state_d;
    logic [KEY_BITS-1:0] key_q, key_d;
    logic [127:0]        data_q, data_d;
    logic [127:0]        result_q, result_d;
    logic [KCW-1:0]      kcnt_q, kcnt_d;
    logic [4:0]          dcnt_q, dcnt_d;
    logic [WW-1:0]       wcnt_q, wcnt_d;
    logic [3:0]          ridx_q, ridx_d;
    logic                mode_q, mode_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                key_full_q, key_full_d;
    logic                data_full_q, data_full_d;

    logic         cmd_fire;
    logic [1:0]   cmd_code;
    logic [127:0] enc_out, dec_out;
    logic [6:0]   rbase;
    logic         unused_bits;

    assign cmd_code    = uio_in[6:5];
    assign unused_bits = ^uio_in[3:0];

    aes_cmd_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .strobe   (uio_in[7]),
        .cmd_fire (cmd_fire)
    );

    AES_Encrypt #(.N(KEY_BITS)) u_enc (.in(data_q), .key(key_q), .out(enc_out));
    AES_Decrypt #(.N(KEY_BITS)) u_dec (.in(data_q), .key(key_q), .out(dec_out));

    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        data_d   = data_q;
        result_d = result_q;
        kcnt_d   = kcnt_q;
        dcnt_d   = dcnt_q;
        wcnt_d   = wcnt_q;
        ridx_d   = ridx_q;
        mode_d   = mode_q;
        busy_d   = busy_q;
        done_d   = done_q;

        if (cmd_fire) begin
            case (cmd_code)
                CMD_LOAD_KEY: if (state_q != RUN) begin
                    key_d = {key_q[KEY_BITS-9:0], ui_in};
                    if (kcnt_q != KEY_FULL_CNT) kcnt_d = kcnt_q + 1'b1;
                end
                CMD_LOAD_DATA: if (state_q != RUN) begin
                    data_d = {data_q[119:0], ui_in};
                    if (dcnt_q != 5'd16) dcnt_d = dcnt_q + 1'b1;
                end
                CMD_START: if (state_q != RUN && key_full_q && data_full_q) begin
                    mode_d  = uio_in[4];
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    wcnt_d  = WW'(CORE_WAIT);
                    state_d = RUN;
                end
                default: if (state_q == DONE) ridx_d = ridx_q + 1'b1;
            endcase
        end

        // Capture happens on the edge that takes the counter from 1 to 0.
        if (ena && state_q == RUN) begin
            wcnt_d = wcnt_q - 1'b1;
            if (wcnt_q == WW'(1)) begin
                result_d = mode_q ? dec_out : enc_out;
                ridx_d   = '0;
                busy_d   = 1'b0;
                done_d   = 1'b1;
                state_d  = DONE;
            end
        end

        key_full_d  = (kcnt_d == KEY_FULL_CNT);
        data_full_d = (dcnt_d == 5'd16);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            key_q       <= '0;
            data_q      <= '0;
            result_q    <= '0;
            kcnt_q      <= '0;
            dcnt_q      <= '0;
            wcnt_q      <= '0;
            ridx_q      <= '0;
            mode_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            key_full_q  <= 1'b0;
            data_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            data_q      <= data_d;
            result_q    <= result_d;
            kcnt_q      <= kcnt_d;
            dcnt_q      <= dcnt_d;
            wcnt_q      <= wcnt_d;
            ridx_q      <= ridx_d;
            mode_q      <= mode_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            key_full_q  <= key_full_d;
            data_full_q <= data_full_d;
        end
    end

    always_comb begin
        rbase   = {~ridx_q, 3'b000};
        uo_out  = done_q ? result_q[rbase +: 8] : 8'h00;
        uio_out = '0;
        uio_out[STAT_BUSY]      = busy_q;
        uio_out[STAT_DONE]      = done_q;
        uio_out[STAT_KEY_FULL]  = key_full_q;
        uio_out[STAT_DATA_FULL] = data_full_q;
    end

    assign uio_oe = UIO_OE;

endmodule

// File: tb/tb_tt_um_aes_stream.sv
// Directed bench for tt_um_aes_stream: an AES-128 instance (CORE_WAIT=8) and
// an AES-256 instance (CORE_WAIT=3) share the host pins.
module tb_tt_um_aes_stream;

    logic       clk = 1'b0;
    logic       rst_n, ena;
    logic [7:0] ui_in, uio_in;
    logic [7:0] uo_out, uio_out, uio_oe;
    logic [7:0] uo_out_b, uio_out_b, uio_oe_b;

    int unsigned tests_run = 0;
    int unsigned tests_failed = 0;
    int unsigned lat, lat_b;
    logic        busy_t, done_t;

    logic [7:0] exp_enc [16] = '{8'h69, 8'hc4, 8'he0, 8'hd8, 8'h6a, 8'h7b, 8'h04, 8'h30,
                                 8'hd8, 8'hcd, 8'hb7, 8'h80, 8'h70, 8'hb4, 8'hc5, 8'h5a};
    logic [7:0] exp_256 [16] = '{8'h8e, 8'ha2, 8'hb7, 8'hca, 8'h51, 8'h67, 8'h45, 8'hbf,
                                 8'hea, 8'hfc, 8'h49, 8'h90, 8'h4b, 8'h49, 8'h60, 8'h89};

    always #5 clk = ~clk;

    tt_um_aes_stream #(.KEY_BITS(128), .CORE_WAIT(8)) dut (
        .ui_in(ui_in), .uo_out(uo_out), .uio_in(uio_in), .uio_out(uio_out),
        .uio_oe(uio_oe), .ena(ena), .clk(clk), .rst_n(rst_n)
    );

    tt_um_aes_stream #(.KEY_BITS(256), .CORE_WAIT(3)) dut256 (
        .ui_in(ui_in), .uo_out(uo_out_b), .uio_in(uio_in), .uio_out(uio_out_b),
        .uio_oe(uio_oe_b), .ena(ena), .clk(clk), .rst_n(rst_n)
    );

    task automatic send_cmd(input logic [1:0] code, input logic [7:0] b, input logic mode);
        @(negedge clk);
        ui_in  = b;
        uio_in = {1'b1, code, mode, 4'h0};
        repeat (3) @(negedge clk);
        uio_in[7] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic load_key_seq(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) send_cmd(2'b00, 8'(i), 1'b0);
    endtask

    task automatic load_data_seq(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) send_cmd(2'b01, 8'(8'h11 * i), 1'b0);
    endtask

    // Issues START; records status right after the executing edge and the
    // cycle on which done rises in each DUT (0 = not within 12 cycles).
    task automatic do_start(input logic mode);
        @(negedge clk);
        uio_in = {1'b1, 2'b10, mode, 4'h0};
        repeat (3) @(posedge clk);
        #1;
        busy_t = uio_out[0];
        done_t = uio_out[1];
        lat    = 0;
        lat_b  = 0;
        for (int unsigned c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            if (uio_out[1] && lat == 0) lat = c;
            if (uio_out_b[1] && lat_b == 0) lat_b = c;
            if (c == 2) uio_in[7] = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; ena = 1'b1; ui_in = '0; uio_in = '0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (uo_out !== 8'h00) begin tests_failed++; $display("FAIL reset_uo_out: got %h expected 00", uo_out); end
        tests_run++;
        if (uio_out !== 8'h00) begin tests_failed++; $display("FAIL reset_uio_out: got %h expected 00", uio_out); end
        tests_run++;
        if (uio_oe !== 8'h0f) begin tests_failed++; $display("FAIL reset_uio_oe: got %h expected 0f", uio_oe); end
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (uio_out_b !== 8'h00 || uo_out_b !== 8'h00) begin
            tests_failed++; $display("FAIL reset_256_outputs: got %h/%h expected 00/00", uio_out_b, uo_out_b);
        end
    endtask

    task automatic test_guard_partial_data;
        load_key_seq(16);
        load_data_seq(15);
        tests_run++;
        if (uio_out !== 8'h04) begin tests_failed++; $display("FAIL partial_status: got %h expected 04", uio_out); end
        do_start(1'b0);
        tests_run++;
        if (busy_t !== 1'b0) begin tests_failed++; $display("FAIL partial_start_busy: got %b expected 0", busy_t); end
        tests_run++;
        if (lat !== 0 || uio_out !== 8'h04) begin
            tests_failed++; $display("FAIL partial_start_ignored: lat %0d status %h expected 0/04", lat, uio_out);
        end
    endtask

    task automatic test_encrypt128;
        send_cmd(2'b01, 8'hff, 1'b0);
        tests_run++;
        if (uio_out !== 8'h0c) begin tests_failed++; $display("FAIL enc_full_status: got %h expected 0c", uio_out); end
        do_start(1'b0);
        tests_run++;
        if (busy_t !== 1'b1 || done_t !== 1'b0) begin
            tests_failed++; $display("FAIL enc_start_status: busy %b done %b expected 1/0", busy_t, done_t);
        end
        tests_run++;
        if (lat !== 8) begin tests_failed++; $display("FAIL enc_latency: got %0d expected 8", lat); end
        for (int unsigned i = 0; i < 16; i++) begin
            if (i > 0) send_cmd(2'b11, 8'h00, 1'b0);
            tests_run++;
            if (uo_out !== exp_enc[i]) begin
                tests_failed++; $display("FAIL enc_byte%0d: got %h expected %h", i, uo_out, exp_enc[i]);
            end
        end
    endtask

    task automatic test_wrap;
        for (int unsigned i = 0; i < 2; i++) begin
            send_cmd(2'b11, 8'h00, 1'b0);
            tests_run++;
            if (uo_out !== exp_enc[i] || uio_oe !== 8'h0f) begin
                tests_failed++; $display("FAIL wrap_read%0d: got %h oe %h expected %h oe 0f", 16 + i, uo_out, uio_oe, exp_enc[i]);
            end
        end
    endtask

    task automatic test_decrypt;
        for (int unsigned i = 0; i < 16; i++) begin
            send_cmd(2'b01, exp_enc[i], 1'b0);
            if (i == 0) begin
                tests_run++;
                if (uio_out[1] !== 1'b1 || uo_out !== 8'hc4) begin
                    tests_failed++; $display("FAIL load_in_done: done %b byte %h expected 1/c4", uio_out[1], uo_out);
                end
            end
        end
        do_start(1'b1);
        tests_run++;
        if (busy_t !== 1'b1 || done_t !== 1'b0 || lat !== 8) begin
            tests_failed++; $display("FAIL dec_start: busy %b done %b lat %0d expected 1/0/8", busy_t, done_t, lat);
        end
        for (int unsigned i = 0; i < 16; i++) begin
            if (i > 0) send_cmd(2'b11, 8'h00, 1'b0);
            tests_run++;
            if (uo_out !== 8'(8'h11 * i)) begin
                tests_failed++; $display("FAIL dec_byte%0d: got %h expected %h", i, uo_out, 8'(8'h11 * i));
            end
        end
    endtask

    task automatic test_load_key_while_busy;
        logic busy_at_load;
        int unsigned waited;
        @(negedge clk);
        uio_in = {1'b1, 2'b10, 1'b1, 4'h0};
        repeat (3) @(posedge clk);
        @(negedge clk);
        uio_in[7] = 1'b0;
        repeat (3) @(negedge clk);
        ui_in  = 8'haa;
        uio_in = {1'b1, 2'b00, 1'b0, 4'h0};
        repeat (3) @(posedge clk);
        #1;
        busy_at_load = uio_out[0];
        @(negedge clk);
        uio_in[7] = 1'b0;
        waited = 0;
        while (uio_out[1] !== 1'b1 && waited < 20) begin @(negedge clk); waited++; end
        tests_run++;
        if (busy_at_load !== 1'b1 || uio_out[1] !== 1'b1) begin
            tests_failed++; $display("FAIL busy_load_setup: busy %b done %b expected 1/1", busy_at_load, uio_out[1]);
        end
        for (int unsigned i = 0; i < 16; i++) begin
            if (i > 0) send_cmd(2'b11, 8'h00, 1'b0);
            tests_run++;
            if (uo_out !== 8'(8'h11 * i)) begin
                tests_failed++; $display("FAIL busy_load_byte%0d: got %h expected %h", i, uo_out, 8'(8'h11 * i));
            end
        end
    endtask

    task automatic test_data_overflow;
        send_cmd(2'b01, 8'hee, 1'b0);
        load_data_seq(16);
        do_start(1'b0);
        tests_run++;
        if (lat !== 8) begin tests_failed++; $display("FAIL ovf_latency: got %0d expected 8", lat); end
        for (int unsigned i = 0; i < 16; i++) begin
            if (i > 0) send_cmd(2'b11, 8'h00, 1'b0);
            tests_run++;
            if (uo_out !== exp_enc[i]) begin
                tests_failed++; $display("FAIL ovf_byte%0d: got %h expected %h", i, uo_out, exp_enc[i]);
            end
        end
    endtask

    task automatic test_aes256;
        load_key_seq(32);
        do_start(1'b0);
        tests_run++;
        if (lat_b !== 3) begin tests_failed++; $display("FAIL aes256_latency: got %0d expected 3", lat_b); end
        for (int unsigned i = 0; i < 16; i++) begin
            if (i > 0) send_cmd(2'b11, 8'h00, 1'b0);
            tests_run++;
            if (uo_out_b !== exp_256[i]) begin
                tests_failed++; $display("FAIL aes256_byte%0d: got %h expected %h", i, uo_out_b, exp_256[i]);
            end
        end
    endtask

    task automatic test_reset_midrun;
        @(negedge clk);
        uio_in = {1'b1, 2'b10, 1'b0, 4'h0};
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'h0f) begin
            tests_failed++; $display("FAIL midrun_reset_outputs: got %h %h %h expected 00 00 0f", uo_out, uio_out, uio_oe);
        end
        @(negedge clk);
        uio_in[7] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (uio_out !== 8'h00 || uio_out_b !== 8'h00 || uo_out_b !== 8'h00 || uio_oe_b !== 8'h0f) begin
            tests_failed++; $display("FAIL post_reset_outputs: got %h %h %h %h expected 00 00 00 0f",
                                     uio_out, uio_out_b, uo_out_b, uio_oe_b);
        end
        do_start(1'b0);
        tests_run++;
        if (busy_t !== 1'b0 || lat !== 0) begin
            tests_failed++; $display("FAIL post_reset_start: busy %b lat %0d expected 0/0", busy_t, lat);
        end
        load_key_seq(16);
        do_start(1'b0);
        tests_run++;
        if (busy_t !== 1'b0 || lat !== 0) begin
            tests_failed++; $display("FAIL key_only_start: busy %b lat %0d expected 0/0", busy_t, lat);
        end
        load_data_seq(16);
        do_start(1'b0);
        tests_run++;
        if (busy_t !== 1'b1 || lat !== 8 || uo_out !== 8'h69) begin
            tests_failed++; $display("FAIL reloaded_start: busy %b lat %0d byte %h expected 1/8/69", busy_t, lat, uo_out);
        end
    endtask

    initial begin
        test_reset();
        test_guard_partial_data();
        test_encrypt128();
        test_wrap();
        test_decrypt();
        test_load_key_while_busy();
        test_data_overflow();
        test_aes256();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
